// File: rtl/freq_measure_if.sv
// freq_measure_if: measured signal in, period results and status out
interface freq_measure_if;
  logic        sig_in;
  logic [31:0] half_period;
  logic [31:0] divisor_out;
  logic        valid;
  logic        locked;
  logic        stalled;
  modport master (output sig_in, input half_period, divisor_out, valid, locked, stalled);
  modport slave  (input sig_in, output half_period, divisor_out, valid, locked, stalled);
endinterface

// File: rtl/freq_measure.sv
// freq_measure: counts clk cycles between sig_in edges, reports half period, lock and stall
module freq_measure #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  freq_measure_if.slave bus
);
  typedef enum logic [1:0] {SETTLE, IDLE, MEASURE, STALLED} state_t;
  state_t      r_state, w_state;
  logic        r_s1, r_s2, r_s3;
  logic [31:0] r_cnt, w_cnt, r_hp, w_hp, r_div, w_div;
  logic        r_valid, w_valid, r_locked, w_locked, r_stalled, w_stalled, r_first, w_first;
  logic [1:0]  r_settle, w_settle;
  logic        w_edge;
  assign w_edge = r_s2 ^ r_s3;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state   <= SETTLE;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_cnt     <= '0;
      r_hp      <= '0;
      r_div     <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_stalled <= 1'b0;
      r_first   <= 1'b0;
      r_settle  <= '0;
    end else begin
      r_state   <= w_state;
      r_s1      <= bus.sig_in;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_cnt     <= w_cnt;
      r_hp      <= w_hp;
      r_div     <= w_div;
      r_valid   <= w_valid;
      r_locked  <= w_locked;
      r_stalled <= w_stalled;
      r_first   <= w_first;
      r_settle  <= w_settle;
    end
  // r_first marks the interval right after IDLE/STALLED, which must never report lock
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_hp      = r_hp;
    w_div     = r_div;
    w_valid   = 1'b0;
    w_locked  = r_locked;
    w_stalled = r_stalled;
    w_first   = r_first;
    w_settle  = r_settle;
    case (r_state)
      SETTLE: begin
        w_settle = r_settle + 2'd1;
        w_state  = (r_settle == 2'd2) ? IDLE : SETTLE;
      end
      IDLE: if (w_edge) begin
        w_state = MEASURE;
        w_cnt   = '0;
        w_first = 1'b1;
      end
      MEASURE: if (w_edge) begin
        w_hp     = r_cnt + 32'd1;
        w_div    = r_cnt;
        w_valid  = 1'b1;
        w_cnt    = '0;
        w_locked = !r_first && (r_cnt + 32'd1 == r_hp);
        w_first  = 1'b0;
      end else if (r_cnt == 32'(TIMEOUT - 1)) begin
        w_state   = STALLED;
        w_stalled = 1'b1;
        w_locked  = 1'b0;
      end else begin
        w_cnt = r_cnt + 32'd1;
      end
      STALLED: if (w_edge) begin
        w_state   = MEASURE;
        w_stalled = 1'b0;
        w_cnt     = '0;
        w_first   = 1'b1;
      end
    endcase
  end
  assign bus.half_period = r_hp;
  assign bus.divisor_out = r_div;
  assign bus.valid       = r_valid;
  assign bus.locked      = r_locked;
  assign bus.stalled     = r_stalled;
endmodule
